mips_dmem_responder: RTL and testbench

Data-memory responder: the target end of the CPU's load/store memory interface. It accepts one word request over a valid/ready handshake and performs a byte-addressable little-endian read or byte-enabled write after a programmable latency. It returns the result over a valid/ready response channel. It replaces the zero-latency combinational data memory, so the CPU and later pipelined cores can be exercised against a realistic, stallable memory.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mips_byte_ram.sv | 34 +++
 rtl/mips_dmem_responder.sv | 130 +++++++++++++
 tb/tb_mips_dmem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS memory-side blocks.
// Holds the data-memory responder state encoding and word-alignment check.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } t_dmem_state;

  localparam int WORD_BYTES = 4;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mips_byte_ram.sv
// Byte-addressable storage: synchronous byte-enabled word write, combinational
// little-endian word read. Both ports share one word index; contents are not reset.
module mips_byte_ram
  import mips_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int IW          = (DEPTH_BYTES > WORD_BYTES) ? $clog2(DEPTH_BYTES / WORD_BYTES) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [7:0] mem_q [DEPTH_BYTES];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        if (be_i[k]) mem_q[{idx_i, 2'(k)}] <= wdata_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      rdata_o[8*k +: 8] = mem_q[{idx_i, 2'(k)}];
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory target: one outstanding request, access after LATENCY cycles,
// response held in registers until rsp_ready; no new request accepted meanwhile.
module mips_dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IW = (DEPTH_BYTES > WORD_BYTES) ? $clog2(DEPTH_BYTES / WORD_BYTES) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
  localparam logic [31:0]   LAST_WORD = 32'(DEPTH_BYTES - WORD_BYTES);

  t_dmem_state state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic        accept;
  logic        fire;
  logic        addr_err;
  logic        ram_we;
  logic [31:0] ram_rdata;

  assign accept   = req_valid && req_ready;
  assign fire     = (state_q == WAIT) && (cnt_q == '0);
  assign addr_err = !is_word_aligned(addr_q) || (addr_q > LAST_WORD);
  assign ram_we   = fire && write_q && !addr_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Request fields are captured only on acceptance; the write commits on the edge entering RESP.
  always_comb begin
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      cnt_d   = CNT_LOAD;
      write_d = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      be_d    = req_be;
    end
    if ((state_q == WAIT) && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    if (fire) begin
      rdata_d = (addr_err || write_q) ? 32'h0 : ram_rdata;
      err_d   = addr_err;
    end
    if ((state_q == RESP) && rsp_ready) begin
      rdata_d = 32'h0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  mips_byte_ram #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .IW         (IW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we),
    .idx_i  (addr_q[IW+1:2]),
    .be_i   (be_q),
    .wdata_i(wdata_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed bench for mips_dmem_responder: LATENCY=2 instance for function and
// backpressure, LATENCY=1 instance with rsp_ready tied high for throughput.
module tb_mips_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        req_valid1, req_ready1, req_write1, rsp_valid1, rsp_err1;
  logic [31:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [3:0]  req_be1;

  int n_checks = 0;
  int n_fail   = 0;

  mips_dmem_responder #(.DEPTH_BYTES(128), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips_dmem_responder #(.DEPTH_BYTES(128), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
    .rsp_valid(rsp_valid1), .rsp_ready(1'b1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the DUT idle and rsp_ready high.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, output logic [31:0] rd, output logic er,
                      output int lat);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFF; req_wdata = '1; req_be = '1;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic run(input string tag, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(wr, a, d, be, rd, er, lat);
    check({tag, "_lat"}, lat, 2);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, er, exp_err);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1'b1;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0; req_be1 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run("sw10", 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0);
    run("lw10", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    run("sw20_pre", 1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 0);
    run("sw20_part", 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0);
    run("lw20", 0, 32'h20, 32'h0, 4'b1111, 32'h11BB33DD, 0);
    run("lw21_misal", 0, 32'h21, 32'h0, 4'b1111, 32'h0, 1);
    run("sw7c", 1, 32'h7C, 32'hCAFEF00D, 4'b1111, 32'h0, 0);
    run("sw80_oor", 1, 32'h80, 32'h55555555, 4'b1111, 32'h0, 1);
    run("swfffc_oor", 1, 32'hFFFF_FFFC, 32'h66666666, 4'b1111, 32'h0, 1);
    run("lw7c", 0, 32'h7C, 32'h0, 4'b0000, 32'hCAFEF00D, 0);
    run("lw7e_misal", 0, 32'h7E, 32'h0, 4'b0000, 32'h0, 1);
    run("sw10_be0", 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);
    run("lw10_after_be0", 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0);

    // Backpressure: a second request waits on req_valid while the first response stalls.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 0; req_addr = 32'h10; req_be = 4'b0000;
    @(posedge clk); #1;
    req_addr = 32'h20;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", lat, 2);
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_hs_valid", rsp_valid, 0);
    check("bp_after_hs_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_second_lat", lat, 2);
    check("bp_second_rdata", rsp_rdata, 32'h11BB33DD);
    @(posedge clk); #1;

    // Reset while a store is in WAIT: the store must be dropped.
    run("sw30_pre", 1, 32'h30, 32'hA5A5A5A5, 4'b1111, 32'h0, 0);
    req_valid = 1'b1; req_write = 1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'b1111;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_wait_req_ready", req_ready, 0);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run("lw30_after_rst", 0, 32'h30, 32'h0, 4'b0000, 32'hA5A5A5A5, 0);

    // Reset while a load response is held: registered data must clear immediately.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 0; req_addr = 32'h30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_hold_rdata", rsp_rdata, 32'hA5A5A5A5);
    rst = 1'b1;
    #1;
    check("resp_rst_rdata", rsp_rdata, 0);
    check("resp_rst_valid", rsp_valid, 0);
    check("resp_rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    // LATENCY=1, rsp_ready tied high: one acceptance every 3 cycles, 1-cycle rsp_valid pulse.
    req_valid1 = 1'b1; req_write1 = 1; req_addr1 = 32'h40; req_wdata1 = 32'h5; req_be1 = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("l1_req_ready_c%0d", c), req_ready1, (c % 3) == 0);
      check($sformatf("l1_rsp_valid_c%0d", c), rsp_valid1, (c % 3) == 2);
      if ((c % 3) == 2) check($sformatf("l1_rsp_err_c%0d", c), rsp_err1, 0);
    end
    req_valid1 = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
